instr_encoder: RTL and testbench

//  Inverse of the immediate decoder: packs opcode, register, funct and a flat
//  32-bit immediate into a 32-bit RV32I instruction word.

---
 rtl/instr_encoder.sv | 172 +++++++++++++++++
 tb/tb_instr_encoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs request fields into an instruction word,
// validates the immediate, and streams {address, instruction} pairs to IMEM.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 1024
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_instr,
  output logic        err_valid,
  output logic [1:0]  err_code
);

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INSN_W = 32;
  localparam int unsigned CNT_W  = 2;

  localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + ADDR_W'(4 * (DEPTH - 1));

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_SB   = 7'b1100011;
  localparam logic [6:0] OP_UJ   = 7'b1101111;
  localparam logic [6:0] OP_U    = 7'b0110111;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_OP    = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_ALIGN = 2'b11;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INSN_W-1:0] instr;
  } entry_t;

  entry_t             head_q, head_d;
  entry_t             tail_q, tail_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   cnt_mid;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               err_valid_q, err_valid_d;
  logic [1:0]         err_code_q, err_code_d;

  logic [INSN_W-1:0]  enc_instr;
  logic [1:0]         enc_err;
  logic               fits12, fits13, fits21;
  logic               accept, push, pop;
  entry_t             new_entry;

  // Range test: upper bits must all replicate the sign bit of the N-bit field
  assign fits12 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign fits13 = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign fits21 = (imm[31:20] == '0) || (imm[31:20] == '1);

  // Format-specific bit placement and error classification (opcode > range > align)
  always_comb begin
    enc_instr = '0;
    enc_err   = ERR_NONE;
    case (opcode)
      OP_R: begin
        enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
      end
      OP_I, OP_JALR: begin
        enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
        if (!fits12) enc_err = ERR_RANGE;
      end
      OP_S: begin
        enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!fits12) enc_err = ERR_RANGE;
      end
      OP_SB: begin
        enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        if (!fits13)      enc_err = ERR_RANGE;
        else if (imm[0])  enc_err = ERR_ALIGN;
      end
      OP_UJ: begin
        enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (!fits21)      enc_err = ERR_RANGE;
        else if (imm[0])  enc_err = ERR_ALIGN;
      end
      OP_U: begin
        enc_instr = {imm[31:12], rd, opcode};
        if (imm[11:0] != '0) enc_err = ERR_ALIGN;
      end
      default: begin
        enc_err = ERR_OP;
      end
    endcase
  end

  assign accept    = in_valid && in_ready_q && !clear;
  assign push      = accept && (enc_err == ERR_NONE);
  assign pop       = out_valid_q && out_ready;
  assign new_entry = '{addr: addr_q, instr: enc_instr};

  // FIFO, address counter and error reporting next-state
  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    cnt_d       = cnt_q;
    cnt_mid     = cnt_q;
    addr_d      = addr_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    if (clear) begin
      cnt_d  = '0;
      addr_d = BASE_ADDR;
    end else begin
      cnt_mid = cnt_q - CNT_W'(pop);
      if (pop && (cnt_q == CNT_W'(2))) head_d = tail_q;
      if (push) begin
        if (cnt_mid == '0) head_d = new_entry;
        else               tail_d = new_entry;
        addr_d = (addr_q == LAST_ADDR) ? BASE_ADDR : addr_q + ADDR_W'(4);
      end
      cnt_d = cnt_mid + CNT_W'(push);
      if (accept && (enc_err != ERR_NONE)) begin
        err_valid_d = 1'b1;
        err_code_d  = enc_err;
      end
    end
    in_ready_d  = (cnt_d < CNT_W'(2));
    out_valid_d = (cnt_d != '0);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      cnt_q       <= '0;
      addr_q      <= BASE_ADDR;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_addr  = head_q.addr;
  assign out_instr = head_q.instr;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH=4 so address wrap is reachable).
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_instr;
  logic        err_valid;
  logic [1:0]  err_code;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  instr_encoder #(.BASE_ADDR(32'h0), .DEPTH(4)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_instr(out_instr),
    .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [6:0] op, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] im);
    opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic do_clear();
    in_valid = 1'b0;
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL reset_out_addr got %h exp 0", out_addr); end
    checks++; if (out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr got %h exp 0", out_instr); end
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL reset_err_valid got %b exp 0", err_valid); end
    checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL reset_err_code got %b exp 00", err_code); end
  endtask

  task automatic test_addi();
    out_ready = 1'b0;
    req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b exp 1", out_valid); end
    checks++; if (out_instr !== 32'h00500093) begin errors++; $display("FAIL addi_instr got %h exp 00500093", out_instr); end
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL addi_addr got %h exp 0", out_addr); end
    step();
    checks++; if (out_instr !== 32'h00500093) begin errors++; $display("FAIL addi_hold got %h exp 00500093", out_instr); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL addi_pop got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_clear();
    out_ready = 1'b1;
    req(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
    step();
    checks++; if (out_instr !== 32'h0020A423) begin errors++; $display("FAIL b2b_sw_instr got %h exp 0020a423", out_instr); end
    checks++; if (out_addr !== 32'h0) begin errors++; $display("FAIL b2b_sw_addr got %h exp 0", out_addr); end
    req(7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
    step();
    in_valid = 1'b0;
    checks++; if (out_instr !== 32'hFE000EE3) begin errors++; $display("FAIL b2b_beq_instr got %h exp fe000ee3", out_instr); end
    checks++; if (out_addr !== 32'h4) begin errors++; $display("FAIL b2b_beq_addr got %h exp 4", out_addr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_formats();
    vec_t v[7];
    v[0] = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h00, 32'd0, 32'h002081B3};
    v[1] = '{7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0, 32'h402081B3};
    v[2] = '{7'h67, 5'd0, 5'd1, 5'd0, 3'd0, 7'h00, 32'd0, 32'h00008067};
    v[3] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048, 32'h001000EF};
    v[4] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4094, 32'h7E000FE3};
    v[5] = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 32'h123452B7};
    v[6] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFF800, 32'h80000093};
    do_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      req(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].f3, v[i].f7, v[i].imm);
      step();
      checks++;
      if (out_instr !== v[i].exp || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL fmt_%0d got %h/%b exp %h/1", i, out_instr, out_valid, v[i].exp);
      end
      checks++;
      if (out_addr !== 32'((i % 4) * 4)) begin
        errors++;
        $display("FAIL fmt_addr_%0d got %h exp %h", i, out_addr, 32'((i % 4) * 4));
      end
    end
    in_valid = 1'b0;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_errors();
    vec_t v[8];
    v[0] = '{7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345001, 32'd3};
    v[1] = '{7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048, 32'd2};
    v[2] = '{7'h00, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'd2048, 32'd1};
    v[3] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4096, 32'd2};
    v[4] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd3, 32'd3};
    v[5] = '{7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'd4097, 32'd2};
    v[6] = '{7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00100000, 32'd2};
    v[7] = '{7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFFF7FF, 32'd2};
    do_clear();
    out_ready = 1'b1;
    req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    step();
    for (int i = 0; i < 8; i++) begin
      req(v[i].op, v[i].rd, v[i].rs1, v[i].rs2, v[i].f3, v[i].f7, v[i].imm);
      step();
      checks++;
      if (err_valid !== 1'b1 || err_code !== v[i].exp[1:0] || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL err_%0d got v%b c%b o%b exp v1 c%b o0", i, err_valid, err_code, out_valid, v[i].exp[1:0]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL err_pulse got %b exp 0", err_valid); end
    checks++; if (err_code !== 2'b10) begin errors++; $display("FAIL err_hold got %b exp 10", err_code); end
    req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    step();
    in_valid = 1'b0;
    checks++; if (out_addr !== 32'h4 || out_valid !== 1'b1) begin errors++; $display("FAIL err_next_addr got %h/%b exp 4/1", out_addr, out_valid); end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    do_clear();
    out_ready = 1'b0;
    req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b exp 1", in_ready); end
    imm = 32'd2;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready2 got %b exp 0", in_ready); end
    imm = 32'd3;
    step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready3 got %b exp 0", in_ready); end
    checks++; if (out_instr !== 32'h00100093 || out_addr !== 32'h0) begin errors++; $display("FAIL bp_headA got %h@%h exp 00100093@0", out_instr, out_addr); end
    out_ready = 1'b1;
    step();
    checks++; if (out_instr !== 32'h00200093 || out_addr !== 32'h4) begin errors++; $display("FAIL bp_headB got %h@%h exp 00200093@4", out_instr, out_addr); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready4 got %b exp 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_instr !== 32'h00300093 || out_addr !== 32'h8) begin errors++; $display("FAIL bp_headC got %h@%h exp 00300093@8", out_instr, out_addr); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got %b exp 0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap_clear();
    logic [31:0] exp_addr [5];
    exp_addr = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h0};
    do_clear();
    out_ready = 1'b1;
    req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7);
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (out_addr !== exp_addr[i] || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL wrap_%0d got %h/%b exp %h/1", i, out_addr, out_valid, exp_addr[i]);
      end
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    checks++; if (out_valid !== 1'b0 || err_valid !== 1'b0) begin errors++; $display("FAIL clear_drop got o%b e%b exp o0 e0", out_valid, err_valid); end
    step();
    in_valid = 1'b0;
    checks++; if (out_addr !== 32'h0 || out_valid !== 1'b1) begin errors++; $display("FAIL clear_addr got %h/%b exp 0/1", out_addr, out_valid); end
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_addr !== 32'h4) begin errors++; $display("FAIL ar_pre got %b@%h exp 1@4", out_valid, out_addr); end
    #2 n_rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_addr !== 32'h0) begin errors++; $display("FAIL ar_flush got o%b r%b a%h exp o0 r1 a0", out_valid, in_ready, out_addr); end
    step();
    n_rst = 1'b1;
    step();
    req(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9);
    step();
    in_valid = 1'b0;
    checks++; if (out_instr !== 32'h00900093 || out_addr !== 32'h0) begin errors++; $display("FAIL ar_post got %h@%h exp 00900093@0", out_instr, out_addr); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    n_rst = 1'b1;
    step();
    test_reset();
    test_addi();
    test_back_to_back();
    test_formats();
    test_errors();
    test_backpressure();
    test_wrap_clear();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
